// File: rtl/rgb_frame_writer.sv
// Raster pixel stream to dual-pixel framebuffer words, one read-modify-write per pixel on port A.
// Latency: read strobe 1 cycle after accept, write strobe READ_LATENCY+1 cycles after the read; 3+READ_LATENCY cycles per pixel.
// Backpressure: o_pix_ready is high only in IDLE/ACCEPT (and low during reset); held low while a pixel is in flight.
module rgb_frame_writer #(
  parameter int WIDTH        = 96,
  parameter int HEIGHT       = 48,
  parameter int BPP          = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [BPP-1:0]   i_pix_data,
  input  logic             i_pix_valid,
  input  logic             i_pix_sof,
  output logic             o_pix_ready,
  output logic [11:0]      o_addr,
  output logic [2*BPP-1:0] o_wdata,
  output logic             o_wr_en,
  output logic             o_rd_en,
  input  logic [2*BPP-1:0] i_rdata,
  output logic             o_frame_done,
  output logic             o_err,
  output logic             o_busy
);

  localparam int HALF = HEIGHT / 2;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_READ, S_WAIT, S_WRITE} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [BPP-1:0]   pix_q, pix_d;
  logic             top_q, top_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [11:0]      addr_q, addr_d;
  logic [2*BPP-1:0] wdata_q, wdata_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic xfer;
  logic last_pix;

  // Top and bottom halves of the panel share a word, so the row folds modulo HALF.
  function automatic logic [11:0] word_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    int r;
    r = int'(row);
    if (r >= HALF) r = r - HALF;
    return 12'(r * WIDTH + int'(col));
  endfunction

  assign o_pix_ready  = !i_rst && (state_q == S_IDLE || state_q == S_ACCEPT);
  assign xfer         = i_pix_valid && o_pix_ready;
  assign last_pix     = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));

  assign o_addr       = addr_q;
  assign o_wdata      = wdata_q;
  assign o_rd_en      = rd_en_q;
  assign o_wr_en      = wr_en_q;
  assign o_frame_done = done_q;
  assign o_err        = err_q;
  assign o_busy       = busy_q;

  // Next-state, coordinate tracking and registered-output computation.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pix_d   = pix_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          if (i_pix_sof) begin
            row_d   = '0;
            col_d   = '0;
            pix_d   = i_pix_data;
            top_d   = 1'b1;
            addr_d  = 12'd0;
            rd_en_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_READ;
          end else begin
            // Pixel outside a frame: dropped, flagged.
            err_d = 1'b1;
          end
        end
      end

      S_ACCEPT: begin
        if (xfer) begin
          pix_d   = i_pix_data;
          rd_en_d = 1'b1;
          state_d = S_READ;
          if (i_pix_sof) begin
            // Early SOF: restart the frame at (0,0) and flag the short frame.
            row_d  = '0;
            col_d  = '0;
            err_d  = 1'b1;
            top_d  = 1'b1;
            addr_d = 12'd0;
          end else begin
            top_d  = (int'(row_q) < HALF);
            addr_d = word_addr(row_q, col_q);
          end
        end
      end

      S_READ: begin
        cnt_d   = 2'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == 2'(READ_LATENCY - 1)) begin
          // Keep the other half of the word, replace ours with the pixel.
          wdata_d = top_q ? {pix_q, i_rdata[BPP-1:0]} : {i_rdata[2*BPP-1:BPP], pix_q};
          wr_en_d = 1'b1;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      S_WRITE: begin
        if (last_pix) begin
          row_d   = '0;
          col_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_ACCEPT;
          if (col_q == CW'(WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight read-modify-write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= '0;
      top_q   <= 1'b0;
      cnt_q   <= 2'd0;
      addr_q  <= 12'd0;
      wdata_q <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Bench for rgb_frame_writer: two instances (READ_LATENCY 1 and 3) each with a framebuffer model.
// Expected writes are queued when pixels are driven and matched against DUT writes.
// Pixel driver waits on o_pix_ready with a bounded cycle budget.
module tb_rgb_frame_writer;

  localparam int W    = 96;
  localparam int H    = 48;
  localparam int HALF = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0][11:0] v_pix;
  logic [1:0]       v_valid;
  logic [1:0]       v_sof;
  logic [1:0][23:0] v_rdata;
  wire  [1:0]       v_ready, v_wr, v_rd, v_done, v_err, v_busy;
  wire  [1:0][11:0] v_addr;
  wire  [1:0][23:0] v_wdata;

  rgb_frame_writer #(.READ_LATENCY(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_data(v_pix[0]), .i_pix_valid(v_valid[0]),
    .i_pix_sof(v_sof[0]), .o_pix_ready(v_ready[0]), .o_addr(v_addr[0]), .o_wdata(v_wdata[0]),
    .o_wr_en(v_wr[0]), .o_rd_en(v_rd[0]), .i_rdata(v_rdata[0]), .o_frame_done(v_done[0]),
    .o_err(v_err[0]), .o_busy(v_busy[0])
  );

  rgb_frame_writer #(.READ_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_pix_data(v_pix[1]), .i_pix_valid(v_valid[1]),
    .i_pix_sof(v_sof[1]), .o_pix_ready(v_ready[1]), .o_addr(v_addr[1]), .o_wdata(v_wdata[1]),
    .o_wr_en(v_wr[1]), .o_rd_en(v_rd[1]), .i_rdata(v_rdata[1]), .o_frame_done(v_done[1]),
    .o_err(v_err[1]), .o_busy(v_busy[1])
  );

  logic [23:0] fb_mem  [2][4096];
  logic [23:0] mdl_mem [2][4096];
  logic [23:0] pipe    [2][3];
  logic [35:0] sb0[$];
  logic [35:0] sb1[$];

  int checks = 0;
  int errors = 0;
  int cyc[2], last_rd_cyc[2], rd_cnt[2], wr_cnt[2], done_cnt[2], err_cnt[2], gap_bad[2];
  int m_row[2], m_col[2], exp_err[2], exp_done[2];
  bit m_busy[2], gap_en[2], have_rd[2];
  logic [11:0] last_rd_addr[2], last_wr_addr[2];
  logic [23:0] last_wr_data[2];

  function automatic int sb_size(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic logic [11:0] pv(input int r, input int c);
    if (r == 0 && (c == 0 || c == 5)) return 12'hABC;
    if (r == 24 && c == 5) return 12'h456;
    return 12'((r * 131 + c * 7 + 3) % 4096);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Framebuffer: capture read at the edge, present it on a negedge so it is stable at the sampling edge.
  task automatic mem_model(input int k);
    int lat;
    lat = (k == 0) ? 1 : 3;
    forever begin
      @(posedge clk);
      if (v_wr[k]) fb_mem[k][v_addr[k]] = v_wdata[k];
      pipe[k][2] = pipe[k][1];
      pipe[k][1] = pipe[k][0];
      pipe[k][0] = fb_mem[k][v_addr[k]];
      @(negedge clk);
      v_rdata[k] = pipe[k][lat-1];
    end
  endtask

  task automatic monitor(input int k);
    int lat;
    logic [35:0] e;
    lat = (k == 0) ? 1 : 3;
    forever begin
      @(negedge clk);
      cyc[k]++;
      if (v_rd[k]) begin
        if (gap_en[k] && have_rd[k] && (cyc[k] - last_rd_cyc[k] != 3 + lat)) gap_bad[k]++;
        have_rd[k]      = 1'b1;
        last_rd_cyc[k]  = cyc[k];
        last_rd_addr[k] = v_addr[k];
        rd_cnt[k]++;
      end
      if (v_wr[k]) begin
        chk("rd_wr_exclusive", 64'(v_rd[k]), 64'd0);
        chk("wr_after_rd_gap", 64'(cyc[k] - last_rd_cyc[k]), 64'(1 + lat));
        chk("wr_addr_eq_rd_addr", 64'(v_addr[k]), 64'(last_rd_addr[k]));
        chk("sb_has_entry", 64'(sb_size(k) != 0), 64'd1);
        if (sb_size(k) != 0) begin
          e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
          chk("sb_write", 64'({v_addr[k], v_wdata[k]}), 64'(e));
        end
        wr_cnt[k]++;
        last_wr_addr[k] = v_addr[k];
        last_wr_data[k] = v_wdata[k];
      end
      if (v_done[k]) begin
        done_cnt[k]++;
        chk("busy_low_with_done", 64'(v_busy[k]), 64'd0);
        chk("done_err_exclusive", 64'(v_err[k]), 64'd0);
      end
      if (v_err[k]) err_cnt[k]++;
    end
  endtask

  // Drive one pixel (called at a negedge), wait for the transfer, update the reference model.
  task automatic send(input int k, input logic [11:0] d, input logic s);
    int n;
    int rr;
    logic [11:0] a;
    logic [23:0] old, nw;
    v_valid[k] = 1'b1;
    v_pix[k]   = d;
    v_sof[k]   = s;
    n = 0;
    while (v_ready[k] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 64'(n < 60), 64'd1);
    @(posedge clk);
    if (s) begin
      if (m_busy[k]) exp_err[k]++;
      m_row[k]  = 0;
      m_col[k]  = 0;
      m_busy[k] = 1'b1;
    end else if (!m_busy[k]) begin
      exp_err[k]++;
    end
    if (m_busy[k]) begin
      rr  = (m_row[k] >= HALF) ? m_row[k] - HALF : m_row[k];
      a   = 12'(rr * W + m_col[k]);
      old = mdl_mem[k][a];
      nw  = (m_row[k] < HALF) ? {d, old[11:0]} : {old[23:12], d};
      mdl_mem[k][a] = nw;
      if (k == 0) sb0.push_back({a, nw}); else sb1.push_back({a, nw});
      if (m_col[k] == W - 1) begin
        m_col[k] = 0;
        if (m_row[k] == H - 1) begin
          m_row[k]  = 0;
          m_busy[k] = 1'b0;
          exp_done[k]++;
        end else begin
          m_row[k]++;
        end
      end else begin
        m_col[k]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (sb_size(k) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb_size(k)), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, rd0, wr0, e0;
    logic [23:0] save;

    rst     = 1'b1;
    v_valid = '0;
    v_sof   = '0;
    v_pix   = '0;
    v_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4096; i++) begin
        fb_mem[k][i]  = 24'd0;
        mdl_mem[k][i] = 24'd0;
      end
      for (int i = 0; i < 3; i++) pipe[k][i] = 24'd0;
      cyc[k] = 0; last_rd_cyc[k] = 0; rd_cnt[k] = 0; wr_cnt[k] = 0; done_cnt[k] = 0;
      err_cnt[k] = 0; gap_bad[k] = 0; m_row[k] = 0; m_col[k] = 0; exp_err[k] = 0;
      exp_done[k] = 0; m_busy[k] = 1'b0; gap_en[k] = 1'b0; have_rd[k] = 1'b0;
      last_rd_addr[k] = 12'd0; last_wr_addr[k] = 12'd0; last_wr_data[k] = 24'd0;
    end

    fork
      mem_model(0);
      mem_model(1);
      monitor(0);
      monitor(1);
    join_none

    // Reset values, then ready in the first cycle after reset.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("reset_outputs", 64'({v_ready[k], v_addr[k], v_wdata[k], v_wr[k], v_rd[k],
                                v_done[k], v_err[k], v_busy[k]}), 64'd0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk("ready_after_reset", 64'(v_ready[k]), 64'd1);
    @(negedge clk);
    chk("busy_idle", 64'(v_busy[0]), 64'd0);

    // Full frame with valid held high; includes the preloaded word 5 and the row-24 merge.
    fb_mem[0][5]  = 24'h000123;
    mdl_mem[0][5] = 24'h000123;
    gap_en[0]     = 1'b1;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(0, pv(r, c), (r == 0 && c == 0));
        if (r == 0 && c == 5) begin
          chk("px5_rd_en", 64'(v_rd[0]), 64'd1);
          chk("px5_rd_addr", 64'(v_addr[0]), 64'd5);
        end
        if (r == 20 && c == 0) chk("busy_mid_frame", 64'(v_busy[0]), 64'd1);
      end
    end
    v_valid[0] = 1'b0;
    n = 0;
    while (done_cnt[0] == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("frame_done_once", 64'(done_cnt[0]), 64'd1);
    chk("frame_done_model", 64'(done_cnt[0]), 64'(exp_done[0]));
    chk("writes_per_frame", 64'(wr_cnt[0]), 64'd4608);
    chk("last_addr", 64'(last_wr_addr[0]), 64'd2303);
    chk("rd_spacing", 64'(gap_bad[0]), 64'd0);
    chk("busy_after_frame", 64'(v_busy[0]), 64'd0);
    chk("sb_drained", 64'(sb_size(0)), 64'd0);
    chk("mem5_merged", 64'(fb_mem[0][5]), 64'h0ABC456);
    chk("mem2303", 64'(fb_mem[0][2303]), 64'({pv(23, 95), pv(47, 95)}));
    chk("no_err_in_frame", 64'(err_cnt[0]), 64'd0);
    gap_en[0] = 1'b0;

    // Pixel without SOF while idle.
    rd0 = rd_cnt[0];
    wr0 = wr_cnt[0];
    e0  = err_cnt[0];
    send(0, 12'h777, 1'b0);
    v_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_err_pulse", 64'(err_cnt[0]), 64'(e0 + 1));
    chk("idle_no_rd", 64'(rd_cnt[0]), 64'(rd0));
    chk("idle_no_wr", 64'(wr_cnt[0]), 64'(wr0));
    chk("idle_ready", 64'(v_ready[0]), 64'd1);
    chk("idle_not_busy", 64'(v_busy[0]), 64'd0);

    // SOF arriving as pixel 100 of a frame.
    for (int i = 0; i < 100; i++) send(0, 12'(i * 3 + 12'h200), (i == 0));
    send(0, 12'hE1E, 1'b1);
    v_valid[0] = 1'b0;
    drain(0);
    chk("resync_err", 64'(err_cnt[0]), 64'(e0 + 2));
    chk("err_model", 64'(err_cnt[0]), 64'(exp_err[0]));
    chk("resync_addr", 64'(last_wr_addr[0]), 64'd0);
    chk("resync_top", 64'(last_wr_data[0][23:12]), 64'h0E1E);
    chk("resync_bottom", 64'(last_wr_data[0][11:0]), 64'(pv(24, 0)));
    chk("resync_no_done", 64'(done_cnt[0]), 64'd1);

    // Reset while the read-modify-write for (0,1) sits in WAIT.
    save = mdl_mem[0][1];
    wr0  = wr_cnt[0];
    send(0, 12'h0F0, 1'b0);
    v_valid[0] = 1'b0;
    chk("pre_reset_in_read", 64'(v_rd[0]), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_low_in_reset", 64'(v_ready[0]), 64'd0);
    @(negedge clk);
    chk("reset_mid_outputs", 64'({v_ready[0], v_addr[0], v_wdata[0], v_wr[0], v_rd[0],
                                  v_done[0], v_err[0], v_busy[0]}), 64'd0);
    void'(sb0.pop_back());
    mdl_mem[0][1] = save;
    m_busy[0] = 1'b0;
    m_row[0]  = 0;
    m_col[0]  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_write_after_reset", 64'(wr_cnt[0]), 64'(wr0));
    chk("mem_unmodified", 64'(fb_mem[0][1]), 64'(save));
    send(0, 12'h3C3, 1'b1);
    v_valid[0] = 1'b0;
    drain(0);
    chk("restart_addr0", 64'(last_wr_addr[0]), 64'd0);
    chk("restart_top", 64'(last_wr_data[0][23:12]), 64'h03C3);

    // READ_LATENCY=3 instance: short run, merge into preloaded word 7.
    fb_mem[1][7]  = 24'h000321;
    mdl_mem[1][7] = 24'h000321;
    gap_en[1]     = 1'b1;
    for (int c = 0; c < 8; c++) send(1, (c == 7) ? 12'h9C9 : 12'(c * 17 + 5), (c == 0));
    v_valid[1] = 1'b0;
    drain(1);
    chk("l3_mem7", 64'(fb_mem[1][7]), 64'h09C9321);
    chk("l3_writes", 64'(wr_cnt[1]), 64'd8);
    chk("l3_reads", 64'(rd_cnt[1]), 64'd8);
    chk("l3_rd_spacing", 64'(gap_bad[1]), 64'd0);
    chk("l3_sb", 64'(sb_size(1)), 64'd0);
    chk("l3_no_err", 64'(err_cnt[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
